// File: rtl/network_bf_out.sv
// Write-back crossbar from the two butterfly units to the four coefficient banks.
// Bank selects, write addresses and enables are taken at issue time. They travel
// down a bf_lat-deep delay line so that they meet the butterfly results, which
// arrive bf_lat cycles later. The selected result is then registered as the bank
// write data, together with the write address and write enable.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   issue_valid, last         issue strobe and end-of-stage tag
//   sel_b_k, wa_in_k, en_k    per-bank source select, write address, enable (k=0..3)
//   x0, y0, x1, y1            butterfly results, valid bf_lat cycles after issue
//   dk, wak, wek              registered bank write data / address / enable
//   busy, inflight, done      in-flight occupancy and last-write drain pulse
module network_bf_out #(
    parameter int unsigned data_width = 23,
    parameter int unsigned addr_width = 6,
    parameter int unsigned bf_lat     = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          issue_valid,
    input  logic [1:0]                    sel_b_0,
    input  logic [1:0]                    sel_b_1,
    input  logic [1:0]                    sel_b_2,
    input  logic [1:0]                    sel_b_3,
    input  logic [addr_width-1:0]         wa_in_0,
    input  logic [addr_width-1:0]         wa_in_1,
    input  logic [addr_width-1:0]         wa_in_2,
    input  logic [addr_width-1:0]         wa_in_3,
    input  logic                          en_0,
    input  logic                          en_1,
    input  logic                          en_2,
    input  logic                          en_3,
    input  logic                          last,
    input  logic [data_width-1:0]         x0,
    input  logic [data_width-1:0]         y0,
    input  logic [data_width-1:0]         x1,
    input  logic [data_width-1:0]         y1,
    output logic [data_width-1:0]         d0,
    output logic [data_width-1:0]         d1,
    output logic [data_width-1:0]         d2,
    output logic [data_width-1:0]         d3,
    output logic [addr_width-1:0]         wa0,
    output logic [addr_width-1:0]         wa1,
    output logic [addr_width-1:0]         wa2,
    output logic [addr_width-1:0]         wa3,
    output logic                          we0,
    output logic                          we1,
    output logic                          we2,
    output logic                          we3,
    output logic                          busy,
    output logic [$clog2(bf_lat+2)-1:0]   inflight,
    output logic                          done
);

    localparam int unsigned CNT_W = $clog2(bf_lat + 2);
    localparam int unsigned NB    = 4;

    typedef struct packed {
        logic                             valid;
        logic                             last;
        logic [NB-1:0][1:0]               sel;
        logic [NB-1:0][addr_width-1:0]    wa;
        logic [NB-1:0]                    en;
    } entry_t;

    entry_t [bf_lat-1:0]              dl_q, dl_d;
    entry_t                           new_e;
    entry_t                           head;
    logic [NB-1:0][data_width-1:0]    src;
    logic [NB-1:0][data_width-1:0]    d_q, d_d;
    logic [NB-1:0][addr_width-1:0]    wa_q, wa_d;
    logic [NB-1:0]                    we_q, we_d;
    logic                             out_valid_q, out_valid_d;
    logic                             done_q, done_d;
    logic                             busy_q, busy_d;
    logic [CNT_W-1:0]                 inflight_q, inflight_d;

    // Issue capture: idle cycles enter the line as an all-zero bubble.
    always_comb begin
        new_e = '0;
        if (issue_valid) begin
            new_e.valid = 1'b1;
            new_e.last  = last;
            new_e.sel   = {sel_b_3, sel_b_2, sel_b_1, sel_b_0};
            new_e.wa    = {wa_in_3, wa_in_2, wa_in_1, wa_in_0};
            new_e.en    = {en_3, en_2, en_1, en_0};
        end
    end

    // Free-running delay line, shifted every cycle.
    always_comb begin
        dl_d    = dl_q;
        dl_d[0] = new_e;
        for (int unsigned i = 1; i < bf_lat; i++) begin
            dl_d[i] = dl_q[i-1];
        end
    end

    assign head = dl_q[bf_lat-1];
    assign src  = {y1, x1, y0, x0};

    // Output stage: route the head entry's chosen source to each bank. Data and
    // address hold across bubbles so the bank ports do not toggle needlessly.
    always_comb begin
        d_d         = d_q;
        wa_d        = wa_q;
        we_d        = '0;
        out_valid_d = head.valid;
        done_d      = head.valid & head.last;
        if (head.valid) begin
            for (int unsigned k = 0; k < NB; k++) begin
                d_d[k]  = src[head.sel[k]];
                wa_d[k] = head.wa[k];
                we_d[k] = head.en[k];
            end
        end
    end

    // Occupancy: an entry counts from issue until it leaves the output register.
    // The count is bounded by bf_lat+1 because a full pipe always retires.
    always_comb begin
        inflight_d = inflight_q + CNT_W'(issue_valid) - CNT_W'(out_valid_q);
        busy_d     = (inflight_d != '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dl_q        <= '0;
            d_q         <= '0;
            wa_q        <= '0;
            we_q        <= '0;
            out_valid_q <= 1'b0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
            inflight_q  <= '0;
        end else begin
            dl_q        <= dl_d;
            d_q         <= d_d;
            wa_q        <= wa_d;
            we_q        <= we_d;
            out_valid_q <= out_valid_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
            inflight_q  <= inflight_d;
        end
    end

    assign d0       = d_q[0];
    assign d1       = d_q[1];
    assign d2       = d_q[2];
    assign d3       = d_q[3];
    assign wa0      = wa_q[0];
    assign wa1      = wa_q[1];
    assign wa2      = wa_q[2];
    assign wa3      = wa_q[3];
    assign we0      = we_q[0];
    assign we1      = we_q[1];
    assign we2      = we_q[2];
    assign we3      = we_q[3];
    assign busy     = busy_q;
    assign inflight = inflight_q;
    assign done     = done_q;

endmodule

// File: tb/tb_network_bf_out.sv
module tb_network_bf_out;

    localparam int unsigned DW  = 23;
    localparam int unsigned AW  = 6;
    localparam int unsigned L   = 4;
    localparam int unsigned CW  = $clog2(L + 2);
    localparam int unsigned WAW = 4 * AW;
    localparam int unsigned XW  = 4 * DW;
    localparam int          NH  = 2048;

    logic          clk = 1'b0;
    logic          rst;
    logic          issue_valid;
    logic          last_i;
    logic [1:0]    sel_v [4];
    logic [AW-1:0] wa_v  [4];
    logic          en_v  [4];
    logic [DW-1:0] x_v   [4];

    wire  [DW-1:0] d_o  [4];
    wire  [AW-1:0] wa_o [4];
    wire           we_o [4];
    wire           busy;
    wire  [CW-1:0] inflight;
    wire           done;

    network_bf_out #(.data_width(DW), .addr_width(AW), .bf_lat(L)) dut (
        .clk(clk), .rst(rst), .issue_valid(issue_valid),
        .sel_b_0(sel_v[0]), .sel_b_1(sel_v[1]), .sel_b_2(sel_v[2]), .sel_b_3(sel_v[3]),
        .wa_in_0(wa_v[0]), .wa_in_1(wa_v[1]), .wa_in_2(wa_v[2]), .wa_in_3(wa_v[3]),
        .en_0(en_v[0]), .en_1(en_v[1]), .en_2(en_v[2]), .en_3(en_v[3]),
        .last(last_i),
        .x0(x_v[0]), .y0(x_v[1]), .x1(x_v[2]), .y1(x_v[3]),
        .d0(d_o[0]), .d1(d_o[1]), .d2(d_o[2]), .d3(d_o[3]),
        .wa0(wa_o[0]), .wa1(wa_o[1]), .wa2(wa_o[2]), .wa3(wa_o[3]),
        .we0(we_o[0]), .we1(we_o[1]), .we2(we_o[2]), .we3(we_o[3]),
        .busy(busy), .inflight(inflight), .done(done)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Per-cycle history of everything driven, indexed by cycle number.
    bit          iv_h   [NH];
    bit          last_h [NH];
    bit          rst_h  [NH];
    bit [1:0]    sel_h  [NH][4];
    bit [AW-1:0] wa_h   [NH][4];
    bit          en_h   [NH][4];
    bit [DW-1:0] x_h    [NH][4];

    logic [DW-1:0] exp_d  [4] = '{default: '0};
    logic [AW-1:0] exp_wa [4] = '{default: '0};
    logic          exp_we [4];
    logic          exp_done;
    logic          exp_busy;
    logic [CW-1:0] exp_inf;

    // An issue at cycle j survives to cycle e if it was valid and no reset hit it.
    function automatic bit alive(int j, int e);
        if (j < 0 || !iv_h[j]) return 1'b0;
        for (int i = j; i <= e; i++) if (rst_h[i]) return 1'b0;
        return 1'b1;
    endfunction

    // Expected outputs during cycle c: writes for the issue of cycle c-L-1 using
    // the results present in cycle c-1; occupancy counts the last L+1 issues.
    task automatic model_update();
        int c, j, cnt;
        c = cyc;
        exp_done = 1'b0;
        for (int k = 0; k < 4; k++) exp_we[k] = 1'b0;
        if (rst_h[c-1]) begin
            for (int k = 0; k < 4; k++) begin exp_d[k] = '0; exp_wa[k] = '0; end
            exp_inf  = '0;
            exp_busy = 1'b0;
        end else begin
            j = c - int'(L) - 1;
            if (alive(j, c - 1)) begin
                for (int k = 0; k < 4; k++) begin
                    exp_d[k]  = x_h[c-1][sel_h[j][k]];
                    exp_wa[k] = wa_h[j][k];
                    exp_we[k] = en_h[j][k];
                end
                exp_done = last_h[j];
            end
            cnt = 0;
            for (int i = c - int'(L) - 1; i < c; i++) if (alive(i, c - 1)) cnt++;
            exp_inf  = CW'(cnt);
            exp_busy = (cnt != 0);
        end
    endtask

    task automatic tick();
        iv_h[cyc]   = issue_valid;
        last_h[cyc] = last_i;
        rst_h[cyc]  = rst;
        for (int k = 0; k < 4; k++) begin
            sel_h[cyc][k] = sel_v[k];
            wa_h[cyc][k]  = wa_v[k];
            en_h[cyc][k]  = en_v[k];
            x_h[cyc][k]   = x_v[k];
        end
        @(posedge clk);
        #1;
        cyc++;
        model_update();
    endtask

    task automatic rand_x();
        for (int k = 0; k < 4; k++) x_v[k] = DW'($urandom);
    endtask

    task automatic set_issue(input logic [7:0] s, input logic [WAW-1:0] w,
                             input logic [3:0] e, input logic lst);
        issue_valid = 1'b1;
        last_i      = lst;
        for (int k = 0; k < 4; k++) begin
            sel_v[k] = s[2*k +: 2];
            wa_v[k]  = w[k*AW +: AW];
            en_v[k]  = e[k];
        end
    endtask

    task automatic set_idle();
        set_issue(8'($urandom), WAW'($urandom), 4'($urandom), 1'($urandom));
        issue_valid = 1'b0;
    endtask

    task automatic set_rand_issue(input logic lst);
        set_issue(8'($urandom), WAW'($urandom), 4'($urandom), lst);
    endtask

    task automatic drain();
        set_idle();
        for (int i = 0; i < int'(L) + 3; i++) begin rand_x(); tick(); end
    endtask

    // Issue one entry, then present xv exactly L cycles later; returns in the write cycle.
    task automatic run_one(input logic [7:0] s, input logic [WAW-1:0] w,
                           input logic [3:0] e, input logic [XW-1:0] xv);
        set_issue(s, w, e, 1'b0);
        rand_x();
        tick();
        set_idle();
        for (int i = 0; i < int'(L) - 1; i++) begin rand_x(); tick(); end
        for (int k = 0; k < 4; k++) x_v[k] = xv[k*DW +: DW];
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        set_rand_issue(1'b1);
        rand_x();
        tick();
        tick();
        for (int k = 0; k < 4; k++) begin
            n_tests++;
            if ({d_o[k], wa_o[k], we_o[k]} !== {DW'(0), AW'(0), 1'b0}) begin
                n_fail++;
                $display("FAIL reset bank%0d d/wa/we=%h/%h/%b want 0", k, d_o[k], wa_o[k], we_o[k]);
            end
        end
        n_tests++;
        if ({inflight, busy, done} !== {CW'(0), 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset inflight/busy/done=%0d/%b/%b want 0/0/0", inflight, busy, done);
        end
        rst = 1'b0;
        drain();
    endtask

    task automatic test_single();
        set_issue({2'd3, 2'd2, 2'd1, 2'd0}, {6'd8, 6'd7, 6'd6, 6'd5}, 4'hF, 1'b0);
        rand_x();
        tick();
        set_idle();
        for (int i = 0; i < int'(L); i++) begin
            n_tests++;
            if (inflight !== CW'(1) || we_o[0] !== 1'b0) begin
                n_fail++;
                $display("FAIL single pre-write step%0d inflight=%0d we0=%b want 1/0", i, inflight, we_o[0]);
            end
            if (i == int'(L) - 1) begin
                x_v[0] = 23'd100; x_v[1] = 23'd200; x_v[2] = 23'd300; x_v[3] = 23'd400;
            end else rand_x();
            tick();
        end
        for (int k = 0; k < 4; k++) begin
            n_tests++;
            if ({d_o[k], wa_o[k], we_o[k]} !== {DW'(100 * (k + 1)), AW'(5 + k), 1'b1}) begin
                n_fail++;
                $display("FAIL single write bank%0d d/wa/we=%0d/%0d/%b want %0d/%0d/1",
                         k, d_o[k], wa_o[k], we_o[k], 100 * (k + 1), 5 + k);
            end
        end
        n_tests++;
        if (inflight !== CW'(1) || busy !== 1'b1 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL single write-cycle inflight/busy/done=%0d/%b/%b want 1/1/0", inflight, busy, done);
        end
        rand_x();
        tick();
        for (int k = 0; k < 4; k++) begin
            n_tests++;
            if (we_o[k] !== 1'b0 || d_o[k] !== DW'(100 * (k + 1))) begin
                n_fail++;
                $display("FAIL single after bank%0d we=%b d=%0d want 0/%0d", k, we_o[k], d_o[k], 100 * (k + 1));
            end
        end
        n_tests++;
        if (inflight !== CW'(0) || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL single drained inflight/busy=%0d/%b want 0/0", inflight, busy);
        end
        drain();
    endtask

    task automatic test_routing();
        logic [DW-1:0] want [4];
        want[0] = 23'd4; want[1] = 23'd4; want[2] = 23'd1; want[3] = 23'd3;
        run_one({2'd2, 2'd0, 2'd3, 2'd3}, WAW'($urandom), 4'hF,
                {23'd4, 23'd3, 23'd2, 23'd1});
        for (int k = 0; k < 4; k++) begin
            n_tests++;
            if (d_o[k] !== want[k] || we_o[k] !== 1'b1) begin
                n_fail++;
                $display("FAIL routing bank%0d d=%0d we=%b want %0d/1", k, d_o[k], we_o[k], want[k]);
            end
        end
        drain();
    endtask

    task automatic test_partial();
        logic want_we [4];
        want_we[0] = 1'b1; want_we[1] = 1'b0; want_we[2] = 1'b1; want_we[3] = 1'b0;
        run_one({2'd3, 2'd2, 2'd1, 2'd0}, {6'd43, 6'd42, 6'd41, 6'd40}, 4'b0101, XW'($urandom));
        for (int k = 0; k < 4; k++) begin
            n_tests++;
            if (we_o[k] !== want_we[k] || wa_o[k] !== AW'(40 + k)) begin
                n_fail++;
                $display("FAIL partial bank%0d we=%b wa=%0d want %b/%0d", k, we_o[k], wa_o[k], want_we[k], 40 + k);
            end
        end
        set_idle();
        rand_x();
        tick();
        for (int k = 0; k < 4; k++) begin
            n_tests++;
            if (we_o[k] !== 1'b0) begin
                n_fail++;
                $display("FAIL partial trailing bank%0d we=%b want 0", k, we_o[k]);
            end
        end
        drain();
    endtask

    task automatic test_burst();
        int f, first_we, last_we, we_cnt, done_cnt, done_cyc, max_inf;
        logic busy_after;
        f = cyc; first_we = -1; last_we = -1; we_cnt = 0; done_cnt = 0; done_cyc = -1;
        max_inf = 0; busy_after = 1'bx;
        for (int i = 0; i < 28; i++) begin
            if (i < 16) set_issue(8'($urandom), WAW'($urandom), 4'hF, i == 15);
            else set_idle();
            rand_x();
            tick();
            for (int k = 0; k < 4; k++) begin
                n_tests++;
                if ({d_o[k], wa_o[k], we_o[k]} !== {exp_d[k], exp_wa[k], exp_we[k]}) begin
                    n_fail++;
                    $display("FAIL burst c%0d bank%0d d/wa/we=%h/%h/%b want %h/%h/%b",
                             cyc, k, d_o[k], wa_o[k], we_o[k], exp_d[k], exp_wa[k], exp_we[k]);
                end
            end
            if (we_o[0] === 1'b1) begin
                if (first_we < 0) first_we = cyc;
                last_we = cyc;
                we_cnt++;
            end
            if (done === 1'b1) begin done_cnt++; done_cyc = cyc; end
            if (done_cyc >= 0 && cyc == done_cyc + 1) busy_after = busy;
            if (int'(inflight) > max_inf) max_inf = int'(inflight);
        end
        n_tests++;
        if (we_cnt != 16 || first_we != f + int'(L) + 1 || last_we - first_we != 15) begin
            n_fail++;
            $display("FAIL burst we window count=%0d first=%0d last=%0d want 16/%0d/%0d",
                     we_cnt, first_we, last_we, f + int'(L) + 1, f + int'(L) + 16);
        end
        n_tests++;
        if (max_inf != int'(L) + 1) begin
            n_fail++;
            $display("FAIL burst inflight peak=%0d want %0d", max_inf, L + 1);
        end
        n_tests++;
        if (done_cnt != 1 || done_cyc != last_we || busy_after !== 1'b0) begin
            n_fail++;
            $display("FAIL burst done count=%0d at=%0d busy_after=%b want 1/%0d/0",
                     done_cnt, done_cyc, busy_after, last_we);
        end
    endtask

    task automatic test_reset_mid();
        int bad;
        bad = 0;
        for (int i = 0; i < 3; i++) begin set_issue(8'($urandom), WAW'($urandom), 4'hF, i == 2); rand_x(); tick(); end
        rst = 1'b1;
        set_issue(8'($urandom), WAW'($urandom), 4'hF, 1'b1);
        rand_x();
        tick();
        rst = 1'b0;
        n_tests++;
        if (inflight !== CW'(0) || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid inflight/busy=%0d/%b want 0/0", inflight, busy);
        end
        set_idle();
        for (int i = 0; i < 10; i++) begin
            rand_x();
            tick();
            if (we_o[0] | we_o[1] | we_o[2] | we_o[3] | done | busy) bad++;
        end
        n_tests++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL reset_mid stray activity cycles=%0d want 0", bad);
        end
    endtask

    task automatic test_gap();
        int f, p1, p2, pulses, max_inf, held_bad;
        logic [DW-1:0] held [4];
        f = cyc; p1 = -1; p2 = -1; pulses = 0; max_inf = 0; held_bad = 0;
        for (int i = 0; i < 12; i++) begin
            if (i == 0 || i == 3) set_issue(8'($urandom), WAW'($urandom), 4'hF, 1'b0);
            else set_idle();
            rand_x();
            tick();
            if (we_o[0] === 1'b1) begin
                pulses++;
                if (p1 < 0) begin
                    p1 = cyc;
                    for (int k = 0; k < 4; k++) held[k] = d_o[k];
                end else p2 = cyc;
            end else if (p1 >= 0 && p2 < 0) begin
                for (int k = 0; k < 4; k++) if (d_o[k] !== held[k]) held_bad++;
            end
            if (int'(inflight) > max_inf) max_inf = int'(inflight);
            n_tests++;
            if ({inflight, busy, done} !== {exp_inf, exp_busy, exp_done}) begin
                n_fail++;
                $display("FAIL gap c%0d inflight/busy/done=%0d/%b/%b want %0d/%b/%b",
                         cyc, inflight, busy, done, exp_inf, exp_busy, exp_done);
            end
        end
        n_tests++;
        if (pulses != 2 || p1 != f + int'(L) + 1 || p2 - p1 != 3) begin
            n_fail++;
            $display("FAIL gap pulses=%0d at %0d,%0d want 2 at %0d,%0d",
                     pulses, p1, p2, f + int'(L) + 1, f + int'(L) + 4);
        end
        n_tests++;
        if (held_bad != 0 || max_inf > 2) begin
            n_fail++;
            $display("FAIL gap hold errors=%0d inflight peak=%0d want 0/<=2", held_bad, max_inf);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            rst = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 3) != 0) set_rand_issue(1'($urandom_range(0, 7) == 0));
            else set_idle();
            rand_x();
            tick();
            for (int k = 0; k < 4; k++) begin
                n_tests++;
                if ({d_o[k], wa_o[k], we_o[k]} !== {exp_d[k], exp_wa[k], exp_we[k]}) begin
                    n_fail++;
                    $display("FAIL random c%0d bank%0d d/wa/we=%h/%h/%b want %h/%h/%b",
                             cyc, k, d_o[k], wa_o[k], we_o[k], exp_d[k], exp_wa[k], exp_we[k]);
                end
            end
            n_tests++;
            if ({inflight, busy, done} !== {exp_inf, exp_busy, exp_done}) begin
                n_fail++;
                $display("FAIL random c%0d inflight/busy/done=%0d/%b/%b want %0d/%b/%b",
                         cyc, inflight, busy, done, exp_inf, exp_busy, exp_done);
            end
        end
        rst = 1'b0;
        drain();
    endtask

    initial begin
        rst = 1'b1;
        set_idle();
        rand_x();
        test_reset();
        test_single();
        test_routing();
        test_partial();
        test_burst();
        test_reset_mid();
        test_gap();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
